// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation memory server.
package me_pkg;

    localparam int DW          = 8;
    localparam int R_DEPTH     = 256;
    localparam int S_DEPTH     = 1024;
    localparam int R_AW        = 8;
    localparam int S_AW        = 10;
    localparam int LOAD_BEATS  = R_DEPTH + S_DEPTH;
    localparam int CNT_W       = 11;
    localparam int TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESULT
    } me_srv_state_t;

    typedef struct packed {
        logic [7:0] best_dist;
        logic [3:0] motion_x;
        logic [3:0] motion_y;
        logic       timeout;
    } me_result_t;

endpackage

// File: rtl/me_buf_ram.sv
// Byte buffer with one synchronous write port and N_RD combinational read ports.
module me_buf_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int N_RD  = 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [N_RD-1:0][AW-1:0]  raddr,
    output logic [N_RD-1:0][DW-1:0]  rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; its contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            rdata[i] = mem[raddr[i]];
        end
    end

endmodule

// File: rtl/me_mem_server.sv
// Memory-side responder for the ME engine: loads R and S buffers, runs the engine, returns the result.
// Optional RUN watchdog enabled by defining ME_TIMEOUT_EN.
module me_mem_server
  import me_pkg::*;
#(
  parameter int TIMEOUT_CYC = me_pkg::TIMEOUT_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DW-1:0]   ld_data,
  output logic            me_start,
  input  logic            me_completed,
  input  logic [7:0]      me_best_dist,
  input  logic [3:0]      me_motion_x,
  input  logic [3:0]      me_motion_y,
  input  logic [R_AW-1:0] me_addr_r,
  input  logic [S_AW-1:0] me_addr_s1,
  input  logic [S_AW-1:0] me_addr_s2,
  output logic [DW-1:0]   me_r,
  output logic [DW-1:0]   me_s1,
  output logic [DW-1:0]   me_s2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [7:0]      res_best_dist,
  output logic [3:0]      res_motion_x,
  output logic [3:0]      res_motion_y,
  output logic            res_timeout,
  output logic            busy
);

`ifdef ME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] run_cnt;
`endif

  me_srv_state_t        state, next_state;
  logic [CNT_W-1:0]     count, next_count;
  me_result_t           res, next_res;
  logic                 ld_fire;
  logic                 r_we, s_we;
  logic [S_AW-1:0]      s_waddr;
  logic [1:0][S_AW-1:0] s_raddr;
  logic [1:0][DW-1:0]   s_rdata;

  assign ld_ready = (state == IDLE) || (state == LOAD);
  assign ld_fire  = ld_valid && ld_ready;
  assign busy     = (state != IDLE);

  // The load counter doubles as the write address: below R_DEPTH it targets R, above it S.
  assign r_we    = ld_fire && (count < CNT_W'(R_DEPTH));
  assign s_we    = ld_fire && (count >= CNT_W'(R_DEPTH));
  assign s_waddr = S_AW'(count - CNT_W'(R_DEPTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_count = count;
    next_res   = res;
    unique case (state)
      IDLE: begin
        if (ld_fire) begin
          next_count = CNT_W'(1);
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          if (count == CNT_W'(LOAD_BEATS - 1)) begin
            next_count = '0;
            next_state = RUN;
          end else begin
            next_count = count + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (me_completed) begin
          next_res   = '{best_dist: me_best_dist, motion_x: me_motion_x,
                         motion_y: me_motion_y, timeout: 1'b0};
          next_state = RESULT;
        end
`ifdef ME_TIMEOUT_EN
        else if (run_cnt == TW'(TIMEOUT_CYC - 1)) begin
          next_res   = '{best_dist: 8'hFF, motion_x: 4'h0,
                         motion_y: 4'h0, timeout: 1'b1};
          next_state = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      res       <= '0;
      me_start  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      res       <= next_res;
      me_start  <= (next_state == RUN);
      res_valid <= (next_state == RESULT);
    end
  end

`ifdef ME_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state != RUN) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + TW'(1);
    end
  end
`endif

  assign res_best_dist = res.best_dist;
  assign res_motion_x  = res.motion_x;
  assign res_motion_y  = res.motion_y;
  assign res_timeout   = res.timeout;

  me_buf_ram #(.DW(DW), .DEPTH(R_DEPTH), .AW(R_AW), .N_RD(1)) u_r_ram (
    .clk   (clk),
    .we    (r_we),
    .waddr (count[R_AW-1:0]),
    .wdata (ld_data),
    .raddr (me_addr_r),
    .rdata (me_r)
  );

  assign s_raddr[0] = me_addr_s1;
  assign s_raddr[1] = me_addr_s2;
  assign me_s1      = s_rdata[0];
  assign me_s2      = s_rdata[1];

  me_buf_ram #(.DW(DW), .DEPTH(S_DEPTH), .AW(S_AW), .N_RD(2)) u_s_ram (
    .clk   (clk),
    .we    (s_we),
    .waddr (s_waddr),
    .wdata (ld_data),
    .raddr (s_raddr),
    .rdata (s_rdata)
  );

endmodule

// File: tb/tb_me_mem_server.sv
// Directed self-checking bench for me_mem_server; covers the timeout path when ME_TIMEOUT_EN is defined.
module tb_me_mem_server;
  import me_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          me_start;
  logic          me_completed;
  logic [7:0]    me_best_dist;
  logic [3:0]    me_motion_x;
  logic [3:0]    me_motion_y;
  logic [7:0]    me_addr_r;
  logic [9:0]    me_addr_s1;
  logic [9:0]    me_addr_s2;
  logic [DW-1:0] me_r;
  logic [DW-1:0] me_s1;
  logic [DW-1:0] me_s2;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_best_dist;
  logic [3:0]    res_motion_x;
  logic [3:0]    res_motion_y;
  logic          res_timeout;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  me_mem_server #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_data       (ld_data),
    .me_start      (me_start),
    .me_completed  (me_completed),
    .me_best_dist  (me_best_dist),
    .me_motion_x   (me_motion_x),
    .me_motion_y   (me_motion_y),
    .me_addr_r     (me_addr_r),
    .me_addr_s1    (me_addr_s1),
    .me_addr_s2    (me_addr_s2),
    .me_r          (me_r),
    .me_s1         (me_s1),
    .me_s2         (me_s2),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_best_dist (res_best_dist),
    .res_motion_x  (res_motion_x),
    .res_motion_y  (res_motion_y),
    .res_timeout   (res_timeout),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // R[k] = k, S[k] = ~k (low byte).
  function automatic logic [7:0] pat(input int beat);
    int t;
    if (beat < R_DEPTH) return beat[7:0];
    t = beat - R_DEPTH;
    return ~t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n beats starting at index first; optional 3-cycle ld_valid gap before beat gap_at.
  task automatic load(input int first, input int n, input int gap_at);
    for (int i = first; i < first + n; i++) begin
      if (i == gap_at) begin
        ld_valid = 1'b0;
        ld_data  = 8'hEE;
        repeat (3) tick();
        check("gap_ld_ready", ld_ready, 1);
      end
      ld_valid = 1'b1;
      ld_data  = pat(i);
      if (i == LOAD_BEATS - 1) check("start_before_last", me_start, 0);
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  task automatic check_reads();
    me_addr_r  = 8'h05;
    me_addr_s1 = 10'h3FF;
    me_addr_s2 = 10'h3FF;
    #1;
    check("rd_r_05", me_r, 8'h05);
    check("rd_s1_3ff", me_s1, 8'h00);
    check("rd_s2_3ff", me_s2, 8'h00);
    me_addr_r  = 8'h00;
    me_addr_s1 = 10'h000;
    me_addr_s2 = 10'h012;
    #1;
    check("rd_r_00", me_r, 8'h00);
    check("rd_s1_000", me_s1, 8'hFF);
    check("rd_s2_012", me_s2, 8'hED);
  endtask

  task automatic complete_and_drain(input logic [7:0] bd, input logic [3:0] mx, input logic [3:0] my);
    me_completed = 1'b1;
    me_best_dist = bd;
    me_motion_x  = mx;
    me_motion_y  = my;
    tick();
    check("cmp_res_valid", res_valid, 1);
    check("cmp_best", res_best_dist, bd);
    check("cmp_mx", res_motion_x, mx);
    check("cmp_my", res_motion_y, my);
    check("cmp_timeout", res_timeout, 0);
    check("cmp_start_low", me_start, 0);
    // Engine keeps toggling outputs during the hold; they must be ignored.
    me_best_dist = 8'h55;
    me_motion_x  = 4'h9;
    me_motion_y  = 4'h6;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_fields", {res_best_dist, res_motion_x, res_motion_y}, {bd, mx, my});
      check("hold_ld_ready", ld_ready, 0);
    end
    me_completed = 1'b0;
    res_ready    = 1'b1;
    tick();
    res_ready = 1'b0;
    check("drain_valid", res_valid, 0);
    check("drain_busy", busy, 0);
    check("drain_ld_ready", ld_ready, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    ld_valid     = 1'b0;
    ld_data      = '0;
    me_completed = 1'b0;
    me_best_dist = '0;
    me_motion_x  = '0;
    me_motion_y  = '0;
    me_addr_r    = '0;
    me_addr_s1   = '0;
    me_addr_s2   = '0;
    res_ready    = 1'b0;
    repeat (2) tick();
    check("rst_start", me_start, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_fields", {res_best_dist, res_motion_x, res_motion_y, res_timeout}, 0);
    rst_n = 1'b1;
    tick();

    // First run: gap-free load; completed in IDLE must be ignored.
    me_completed = 1'b1;
    tick();
    check("idle_ignores_cmp", res_valid, 0);
    me_completed = 1'b0;
    load(0, LOAD_BEATS, -1);
    check("start_after_last", me_start, 1);
    check("run_busy", busy, 1);
    check("run_ld_ready", ld_ready, 0);
    check_reads();
    repeat (3) tick();
    check("run_waits", {me_start, res_valid}, 2'b10);
    complete_and_drain(8'h2A, 4'h3, 4'hC);

    // Second run with a stall early in R; stalled beats must not advance the address.
    load(0, LOAD_BEATS, 3);
    check("start_after_gap_load", me_start, 1);
    check_reads();
    complete_and_drain(8'h07, 4'hF, 4'h0);

    // Reset in the middle of a load, then a full reload.
    load(0, 601, -1);
    check("midload_busy", busy, 1);
    check("midload_start", me_start, 0);
    rst_n = 1'b0;
    #2;
    check("mrst_busy", busy, 0);
    check("mrst_ld_ready", ld_ready, 1);
    check("mrst_start", me_start, 0);
    check("mrst_valid", res_valid, 0);
    check("mrst_fields", {res_best_dist, res_motion_x, res_motion_y, res_timeout}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    load(0, LOAD_BEATS - 1, -1);
    check("reload_not_started", me_start, 0);
    check("reload_busy", busy, 1);
    load(LOAD_BEATS - 1, 1, -1);
    check("reload_started", me_start, 1);
    check_reads();
    complete_and_drain(8'h11, 4'h1, 4'h2);

`ifdef ME_TIMEOUT_EN
    load(0, LOAD_BEATS, -1);
    check("to_start", me_start, 1);
    repeat (15) tick();
    check("to_before", {me_start, res_valid}, 2'b10);
    tick();
    check("to_start_low", me_start, 0);
    check("to_valid", res_valid, 1);
    check("to_flag", res_timeout, 1);
    check("to_best", res_best_dist, 8'hFF);
    check("to_mv", {res_motion_x, res_motion_y}, 8'h00);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("to_drain", res_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
